// File: rtl/sine_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the sine generator's incr/en/offset inputs.
// Optional build macro SWEEP_PHASE_RAMP_EN: channel-2 offset walks by offset_cfg on every step.
module sine_sweep_ctrl #(
  parameter int W       = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       incr_start,
  input  logic [W-1:0]       incr_stop,
  input  logic [W-1:0]       incr_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  input  logic [W-1:0]       offset_cfg,
  output logic [W-1:0]       incr,
  output logic [W-1:0]       offset,
  output logic               en,
  output logic               busy,
  output logic               step_tick,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  state_t               state_q, state_d;
  logic [W-1:0]         incr_q, incr_d;
  logic [W-1:0]         offset_q, offset_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 step_tick_q, step_tick_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [W-1:0]         start_val_q, start_val_d;
  logic [W-1:0]         target_q, target_d;
  logic [W-1:0]         step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [1:0]           mode_q, mode_d;
  logic                 dir_up_q, dir_up_d;
`ifdef SWEEP_PHASE_RAMP_EN
  logic [W-1:0]         off_inc_q, off_inc_d;
`endif

  // One step from cur toward tgt; arithmetic in W+1 bits so it clamps instead of wrapping.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt,
                                               input logic         up,
                                               input logic [W-1:0] stp);
    logic [W:0] sum;
    logic [W:0] lim;
    logic [W-1:0] res;
    sum = {1'b0, cur} + {1'b0, stp};
    lim = {1'b0, tgt} + {1'b0, stp};
    if (up) begin
      res = (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
    end else begin
      res = ({1'b0, cur} <= lim) ? tgt : (cur - stp);
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    incr_d      = incr_q;
    offset_d    = offset_q;
    en_d        = en_q;
    busy_d      = busy_q;
    step_tick_d = 1'b0;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    start_val_d = start_val_q;
    target_d    = target_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    dir_up_d    = dir_up_q;
`ifdef SWEEP_PHASE_RAMP_EN
    off_inc_d   = off_inc_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          start_val_d = incr_start;
          target_d    = incr_stop;
          step_d      = (incr_step == '0) ? W'(1) : incr_step;
          dwell_d     = dwell;
          mode_d      = mode;
          dir_up_d    = (incr_stop >= incr_start);
          incr_d      = incr_start;
`ifdef SWEEP_PHASE_RAMP_EN
          off_inc_d   = offset_cfg;
          offset_d    = '0;
`else
          offset_d    = offset_cfg;
`endif
          en_d        = 1'b1;
          busy_d      = 1'b1;
          dwell_cnt_d = '0;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (dwell_cnt_q != dwell_q) begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end else begin
          dwell_cnt_d = '0;
          if (incr_q != target_q) begin
            incr_d      = step_toward(incr_q, target_q, dir_up_q, step_q);
            step_tick_d = 1'b1;
          end else begin
            case (mode_q)
              MODE_LOOP: begin
                incr_d      = start_val_q;
                step_tick_d = 1'b1;
              end
              MODE_PINGPONG: begin
                // Endpoints swap; equal endpoints leave incr parked without a tick.
                target_d    = start_val_q;
                start_val_d = target_q;
                dir_up_d    = ~dir_up_q;
                if (start_val_q != target_q) begin
                  incr_d      = step_toward(incr_q, start_val_q, ~dir_up_q, step_q);
                  step_tick_d = 1'b1;
                end
              end
              default: begin
                state_d = DONE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      incr_d      = '0;
      done_d      = 1'b0;
      step_tick_d = 1'b0;
      dwell_cnt_d = '0;
    end

`ifdef SWEEP_PHASE_RAMP_EN
    if (step_tick_d) begin
      offset_d = offset_q + off_inc_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      incr_q      <= '0;
      offset_q    <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      step_tick_q <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= '0;
      start_val_q <= '0;
      target_q    <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      mode_q      <= '0;
      dir_up_q    <= 1'b0;
`ifdef SWEEP_PHASE_RAMP_EN
      off_inc_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      incr_q      <= incr_d;
      offset_q    <= offset_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      step_tick_q <= step_tick_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      start_val_q <= start_val_d;
      target_q    <= target_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      dir_up_q    <= dir_up_d;
`ifdef SWEEP_PHASE_RAMP_EN
      off_inc_q   <= off_inc_d;
`endif
    end
  end

  assign incr      = incr_q;
  assign offset    = offset_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign step_tick = step_tick_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl: expected increment/offset sequences are queued
// when a sweep is launched and popped by a monitor each time the DUT presents a new value.
module tb_sine_sweep_ctrl;
  localparam int W       = 8;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [W-1:0]       incr_start;
  logic [W-1:0]       incr_stop;
  logic [W-1:0]       incr_step;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         mode;
  logic [W-1:0]       offset_cfg;
  logic [W-1:0]       incr;
  logic [W-1:0]       offset;
  logic               en;
  logic               busy;
  logic               step_tick;
  logic               done;
  logic [1:0]         dbg_state;

  sine_sweep_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .incr_start(incr_start), .incr_stop(incr_stop), .incr_step(incr_step),
    .dwell(dwell), .mode(mode), .offset_cfg(offset_cfg),
    .incr(incr), .offset(offset), .en(en), .busy(busy),
    .step_tick(step_tick), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] off_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_hold = 1;
  int           push_idx = 0;
  logic [W-1:0] cur_off_cfg = '0;
  logic         mon_en = 1'b0;
  logic         prev_en = 1'b0;
  logic [W-1:0] prev_incr = '0;
  int           hold_cnt = 0;
  int           done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    logic [W-1:0] o;
`ifdef SWEEP_PHASE_RAMP_EN
    o = W'(push_idx) * cur_off_cfg;
`else
    o = cur_off_cfg;
`endif
    exp_q.push_back(v);
    off_q.push_back(o);
    push_idx++;
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en && rst) begin
      if (en && (!prev_en || step_tick)) begin
        if (prev_en) check("hold_len", hold_cnt, exp_hold);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_value", incr, 32'hFFFF_FFFF);
        end else begin
          check("incr_seq", incr, exp_q.pop_front());
          check("offset_seq", offset, off_q.pop_front());
        end
      end
      if (en && prev_en) check("tick_on_change", step_tick, incr != prev_incr);
      if (done) begin
        check("hold_len_last", hold_cnt, exp_hold);
        check("tick_at_done", step_tick, 0);
      end
    end
    if (en) hold_cnt = (!prev_en || step_tick) ? 1 : hold_cnt + 1;
    prev_en   = en;
    prev_incr = incr;
  end

  // driver tasks
  task automatic start_sweep(input logic [W-1:0] s, input logic [W-1:0] e,
                             input logic [W-1:0] stp, input int dw,
                             input logic [1:0] md, input logic [W-1:0] off);
    @(negedge clk);
    incr_start = s; incr_stop = e; incr_step = stp;
    dwell = DWELL_W'(dw); mode = md; offset_cfg = off;
    exp_hold = dw + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // config must be ignored after the start edge
    incr_start = W'($urandom_range(0, 255));
    incr_stop  = W'($urandom_range(0, 255));
    incr_step  = W'($urandom_range(0, 255));
    dwell      = DWELL_W'($urandom_range(0, 7));
    mode       = 2'($urandom_range(0, 3));
    offset_cfg = W'($urandom_range(0, 255));
  endtask

  task automatic new_test(input logic [W-1:0] off);
    exp_q.delete();
    off_q.delete();
    push_idx    = 0;
    cur_off_cfg = off;
    done_cnt    = 0;
    mon_en      = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    if (i == budget) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_q_empty(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (i == budget) check({tag, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic do_abort(input string tag);
    mon_en = 1'b0;
    abort  = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check({tag, "_incr"}, incr, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tick"}, step_tick, 0);
    repeat (3) @(negedge clk);
    check({tag, "_no_done"}, done_cnt, 0);
  endtask

  task automatic check_once_end(input string tag, input logic [W-1:0] last);
    check({tag, "_done_en"}, en, 0);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_incr"}, incr, last);
    @(negedge clk); #1;
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_idle_incr"}, incr, last);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    incr_start = '0; incr_stop = '0; incr_step = '0;
    dwell = '0; mode = '0; offset_cfg = '0;
    repeat (3) @(negedge clk);
    check("rst_incr", incr, 0);
    check("rst_offset", offset, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", step_tick, 0);
    check("rst_done", done, 0);
    rst = 1'b1;

    // once, upward
    new_test(0);
    push(10); push(20); push(30); push(40);
    start_sweep(10, 40, 10, 2, 2'd0, 0);
    check("once_busy", busy, 1);
    wait_done("once_up", 200);
    check_once_end("once_up", 40);

    // once, downward with clamp at the final value
    new_test(0);
    push(50); push(30); push(10); push(5);
    start_sweep(50, 5, 20, 0, 2'd0, 0);
    wait_done("once_down", 200);
    check_once_end("once_down", 5);

    // pingpong
    new_test(0);
    push(1); push(2); push(3); push(2); push(1); push(2); push(3);
    start_sweep(1, 3, 1, 0, 2'd2, 0);
    wait_q_empty("pingpong", 200);
    check("pingpong_busy", busy, 1);
    do_abort("pingpong_abort");

    // loop
    new_test(0);
    push(1); push(2); push(3); push(1); push(2); push(3);
    start_sweep(1, 3, 1, 0, 2'd1, 0);
    wait_q_empty("loop", 200);
    check("loop_busy", busy, 1);
    do_abort("loop_abort");

    // abort together with start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    incr_start = 8'd33; incr_stop = 8'd44; incr_step = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_en", en, 0);
    check("abort_start_busy", busy, 0);
    check("abort_start_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    check("abort_start_still_idle", en, 0);

    // abort mid-run at incr=20
    new_test(0);
    push(10); push(20);
    start_sweep(10, 40, 10, 3, 2'd0, 0);
    wait_q_empty("abort_run", 200);
    check("abort_run_at20", incr, 20);
    do_abort("abort_run");

    // step 0 behaves as 1; offset static or ramping depending on build
    new_test(64);
    push(7); push(8); push(9);
    start_sweep(7, 9, 0, 1, 2'd0, 64);
    wait_done("step0", 200);
    check_once_end("step0", 9);

    // async reset mid-run, then a clean restart
    new_test(0);
    push(10);
    start_sweep(10, 40, 10, 5, 2'd0, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_incr", incr, 0);
    check("arst_offset", offset, 0);
    check("arst_en", en, 0);
    check("arst_busy", busy, 0);
    check("arst_tick", step_tick, 0);
    check("arst_done", done, 0);
    check("arst_sb_empty", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    check("arst_no_done", done_cnt, 0);
    new_test(0);
    push(10); push(20); push(30); push(40);
    start_sweep(10, 40, 10, 1, 2'd0, 0);
    wait_done("restart", 200);
    check_once_end("restart", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_sweep_ctrl.md
Name: sine_sweep_ctrl

Overview:
- Sequencer that drives the frequency-control inputs (incr, en, offset) of the two-channel sine generator to produce linear frequency sweeps.
- Steps the phase increment from a start value to a stop value with a programmable step size and dwell time. Supports one-shot, loop and ping-pong modes.
- Sits between the host/config logic and the sine generator. It is the only driver of the generator's incr, en and offset inputs.

Parameters:
- W, 8, width of incr/step/offset values; matches the generator's increment and ROM address width.
- DWELL_W, 16, width of the dwell counter and dwell config.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  stop sweep immediately; any state.
- incr_start  in  W  first increment of the sweep.
- incr_stop  in  W  final increment of the sweep.
- incr_step  in  W  step magnitude; 0 is treated as 1.
- dwell  in  DWELL_W  each increment is held dwell+1 cycles.
- mode  in  2  0=once, 1=loop, 2=pingpong, 3=reserved (behaves as once).
- offset_cfg  in  W  channel-2 phase offset (see Optional Feature).
- incr  out  W  registered increment to the generator.
- offset  out  W  registered offset to the generator.
- en  out  1  generator counter enable.
- busy  out  1  high in RUN.
- step_tick  out  1  1-cycle pulse on each increment change.
- done  out  1  1-cycle pulse at once-mode completion.

Behaviour:
- Reset (rst=0, async): state=IDLE; incr=0, offset=0, en=0, busy=0, step_tick=0, done=0; dwell counter cleared.
- All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE, start=1 and abort=0 at edge N: latch all config inputs (start, stop, step, dwell, mode, offset_cfg). At edge N the registers load incr=incr_start, offset=offset_cfg, en=1, busy=1, dwell_cnt=0, and the state goes to RUN.
- Config inputs are ignored outside the start edge.
- start is ignored while in RUN or DONE.
- Direction: up if stop >= start, else down (latched at start).
- RUN: dwell_cnt increments each cycle. When dwell_cnt == dwell, at the next edge dwell_cnt=0 and the sweep advances:
  - If incr != current target: next = incr ± step, clamped to the target when it would reach or pass it (compare in W+1 bits; no wrap).
  - If incr == target (end of sweep):
    - once: go to DONE.
    - loop: incr reloads the start value.
    - pingpong: swap the target and start values, reverse direction, and step from the endpoint.
  - step_tick=1 in the cycle after each incr change, including a loop reload. It is not asserted on the transition to DONE.
- start == stop: a single value is held for dwell+1 cycles, then end-of-sweep applies. Pingpong with equal endpoints holds the value indefinitely.
- DONE (1 cycle): done=1, en=0, busy=0, incr holds its last value; then IDLE. done falls on the next edge.
- abort=1 in any state: next edge go to IDLE with en=0, busy=0, incr=0, done=0, step_tick=0. abort has priority over start and over step advance.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- incr and en change on the same edge, so the generator never runs with a stale increment.

Optional Feature:
- Macro: SWEEP_PHASE_RAMP_EN.
- Defined: offset starts at 0 and advances by offset_cfg (mod 2^W) on every step_tick edge, so the channel-2 phase walks during the sweep.
- Not defined: offset = offset_cfg latched at start, static for the whole sweep. offset resets to 0 only on rst.

Test Plan:
- rst=0 mid-RUN, asynchronously -> all outputs 0 the same cycle, without waiting for a clk edge. Release, then start -> sweep restarts cleanly from incr_start.
- once, start=10, stop=40, step=10, dwell=2 -> incr 10,20,30,40, each held 3 cycles; done pulses 1 cycle after the 40 hold; en=0 after.
- Down with clamp, once, start=50, stop=5, step=20, dwell=0 -> incr 50,30,10,5; no underflow wrap; done=1 once.
- pingpong, start=1, stop=3, step=1, dwell=0 -> incr 1,2,3,2,1,2,3...; busy stays 1; step_tick on every change. loop with the same settings -> 1,2,3,1,2,3.
- abort and start together in IDLE -> stays IDLE, en=0. Abort during RUN at incr=20 -> next cycle incr=0, en=0, no done pulse.
- step=0, start=7, stop=9 -> behaves as step 1 (7,8,9). With SWEEP_PHASE_RAMP_EN and offset_cfg=64 -> offset 0,64,128 at the steps. Without the macro -> offset=64 constant.
